// File: rtl/sbox_lane_sched_pkg.sv
// sbox_sched_pkg: shared types and helpers for the byte-serial S-box scheduler
package sbox_sched_pkg;
  localparam int NBYTES = 16;
  typedef enum logic [1:0] {IDLE, WAIT_RND, HOLD, DONE} state_e;
  typedef logic [3:0] idx_t;
  function automatic logic [7:0] state_byte(input logic [8*NBYTES-1:0] s, input idx_t i);
    return s[{i, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/sbox_lane_sched_if.sv
// sbox_lane_sched_if: start/randomness/result handshakes plus the S-box core hookup
interface sbox_lane_sched_if #(parameter int D = 8, parameter int NR = 7);
  logic            start_valid;
  logic            start_ready;
  logic [127:0]    state_in;
  logic            rnd_valid;
  logic            rnd_ready;
  logic [NR*D-1:0] rnd_in;
  logic            sb_start;
  logic [7:0]      sb_in;
  logic [NR*D-1:0] sb_r;
  logic [7:0]      sb_out;
  logic            out_valid;
  logic            out_ready;
  logic [127:0]    state_out;
  modport master(
    output start_valid, state_in, rnd_valid, rnd_in, sb_out, out_ready,
    input  start_ready, rnd_ready, sb_start, sb_in, sb_r, out_valid, state_out
  );
  modport slave(
    input  start_valid, state_in, rnd_valid, rnd_in, sb_out, out_ready,
    output start_ready, rnd_ready, sb_start, sb_in, sb_r, out_valid, state_out
  );
endinterface

// File: rtl/sbox_lane_sched_lat_ctr.sv
// sbox_lat_ctr: one-hot shift counter timing the S-box core latency
module sbox_lat_ctr #(
  parameter int LAT = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic first_o,
  output logic done_o
);
  logic [LAT-1:0] ctr_q, ctr_d;
  always_comb ctr_d = load_i ? LAT'(1) : ctr_q << 1;
  always_ff @(posedge clk or posedge rst)
    if (rst) ctr_q <= '0;
    else     ctr_q <= ctr_d;
  assign first_o = ctr_q[0];
  assign done_o  = ctr_q[LAT-1];
endmodule

// File: rtl/sbox_lane_sched.sv
// sbox_lane_sched: feeds 16 state bytes, MSB first, through one masked S-box core
module sbox_lane_sched
  import sbox_sched_pkg::*;
#(
  parameter int D   = 8,
  parameter int NR  = 7,
  parameter int LAT = 9
) (
  input logic clk,
  input logic rst,
  sbox_lane_sched_if.slave bus
);
  localparam int RW = NR * D;
  state_e              state_q, state_d;
  idx_t                idx_q, idx_d;
  logic [8*NBYTES-1:0] st_q, st_d, res_q, res_d;
  logic [RW-1:0]       rnd_q, rnd_d;
  logic                load, first, done;
  sbox_lat_ctr #(.LAT(LAT)) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .first_o(first),
    .done_o (done)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      st_q    <= '0;
      res_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      st_q    <= st_d;
      res_q   <= res_d;
      rnd_q   <= rnd_d;
    end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    st_d    = st_q;
    res_d   = res_q;
    rnd_d   = rnd_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start_valid) begin
        state_d = WAIT_RND;
        st_d    = bus.state_in;
        idx_d   = idx_t'(NBYTES - 1);
        res_d   = '0;
      end
      WAIT_RND: if (bus.rnd_valid) begin
        state_d = HOLD;
        rnd_d   = bus.rnd_in;
        load    = 1'b1;
      end
      HOLD: if (done) begin
        res_d[{idx_q, 3'b000} +: 8] = bus.sb_out;
        rnd_d   = '0;
        state_d = idx_q == '0 ? DONE : WAIT_RND;
        idx_d   = idx_q == '0 ? idx_q : idx_q - 1'b1;
      end
      DONE: if (bus.out_ready) begin
        state_d = IDLE;
        st_d    = '0;
        res_d   = '0;
        rnd_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // core inputs are forced to zero outside HOLD so no share leaks while idle or stalled
  assign bus.start_ready = state_q == IDLE;
  assign bus.rnd_ready   = state_q == WAIT_RND;
  assign bus.sb_start    = state_q == HOLD && first;
  assign bus.sb_in       = state_q == HOLD ? state_byte(st_q, idx_q) : '0;
  assign bus.sb_r        = state_q == HOLD ? rnd_q : '0;
  assign bus.out_valid   = state_q == DONE;
  assign bus.state_out   = state_q == DONE ? res_q : '0;
endmodule
